// File: rtl/encoder_pkg.sv
// rtl/encoder_pkg.sv - shared constants and helpers for the round-robin priority encoder
// Purpose: mode encodings and an index-width helper used by the encoder and its scan.
// Ports: none (package).
package encoder_pkg;

    localparam logic ENC_MODE_FIXED = 1'b0;
    localparam logic ENC_MODE_RR    = 1'b1;

    // Bits needed to index n items; never below 1 so N=2 still gets a real index bit.
    function automatic int clog2_safe(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_priority_scan.sv
// rtl/rr_priority_scan.sv - combinational rotating highest-set-bit scan
// Purpose: find the first set bit of in, scanning downward from ptr with wrap to N-1.
// Ports:
//   in     [N-1:0]  request vector
//   ptr    [W-1:0]  scan start index (N-1 gives plain highest-index priority)
//   winner [W-1:0]  index of the winning request (0 when in is all zeros)
//   zero            in has no bits set
//   multi           in has two or more bits set
module rr_priority_scan
    import encoder_pkg::*;
#(
    parameter int N = 8,
    parameter int W = clog2_safe(N)
) (
    input  logic [N-1:0] in,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] winner,
    output logic         zero,
    output logic         multi
);

    logic [N-1:0] w_rot;
    logic [W-1:0] w_src;
    logic [W-1:0] w_hi;
    logic         w_seen;

    // Rotate right by ptr+1 so bit ptr lands at the MSB; a plain highest-bit
    // search on the rotated vector then gives the descending-with-wrap order.
    always_comb begin
        w_rot = '0;
        w_src = '0;
        for (int j = 0; j < N; j++) begin
            w_src    = W'((j + int'(ptr) + 1) % N);
            w_rot[j] = in[w_src];
        end
    end

    always_comb begin
        w_hi = '0;
        for (int j = 0; j < N; j++) begin
            if (w_rot[j]) begin
                w_hi = W'(j);
            end
        end
    end

    always_comb begin
        w_seen = 1'b0;
        multi  = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (in[j]) begin
                if (w_seen) begin
                    multi = 1'b1;
                end
                w_seen = 1'b1;
            end
        end
    end

    assign zero   = ~|in;
    // Undo the rotation to recover the original bit index.
    assign winner = zero ? '0 : W'((int'(w_hi) + int'(ptr) + 1) % N);

endmodule

// File: rtl/rr_priority_encoder.sv
// rtl/rr_priority_encoder.sv - N-to-log2(N) priority encoder with round-robin mode and handshake
// Purpose: encode a request vector into a registered binary index with zero/multi flags,
//          fixed or rotating priority, and ready/valid flow control on both sides.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   mode                   0 fixed priority (highest index), 1 round-robin; sampled with in
//   in_valid / in_ready    input handshake
//   in        [N-1:0]      request vector
//   out_valid / out_ready  output handshake
//   out       [W-1:0]      winning index
//   out_zero, out_multi    accepted vector was all zeros / had two or more bits set
module rr_priority_encoder
    import encoder_pkg::*;
#(
    parameter int N = 8,
    parameter int W = clog2_safe(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mode,
    input  logic         in_valid,
    input  logic [N-1:0] in,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out,
    output logic         out_zero,
    output logic         out_multi
);

    localparam logic [W-1:0] PTR_TOP = W'(N - 1);

    logic         r_out_valid;
    logic [W-1:0] r_out;
    logic         r_out_zero;
    logic         r_out_multi;
    logic [W-1:0] r_ptr;

    logic [W-1:0] w_scan_ptr;
    logic [W-1:0] w_win;
    logic         w_zero;
    logic         w_multi;
    logic         w_accept;

    // Fixed mode is the rotating scan pinned to start at the top index.
    assign w_scan_ptr = (mode == ENC_MODE_RR) ? r_ptr : PTR_TOP;

    rr_priority_scan #(
        .N(N),
        .W(W)
    ) u_scan (
        .in    (in),
        .ptr   (w_scan_ptr),
        .winner(w_win),
        .zero  (w_zero),
        .multi (w_multi)
    );

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_out_zero  <= 1'b0;
            r_out_multi <= 1'b0;
            r_ptr       <= PTR_TOP;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out       <= w_win;
            r_out_zero  <= w_zero;
            r_out_multi <= w_multi;
            // Next scan starts just below the winner; an empty vector leaves it alone.
            if (mode == ENC_MODE_RR && !w_zero) begin
                r_ptr <= (w_win == '0) ? PTR_TOP : w_win - 1'b1;
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign out_zero  = r_out_zero;
    assign out_multi = r_out_multi;

endmodule
